// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared widths, issue-queue entry type and issue packet packing
package math_pkg;

  localparam int PREG_W      = 6;
  localparam int ROB_W       = 6;
  localparam int ISSUE_PKT_W = 2 * PREG_W + ROB_W;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] rs1;
    logic              r1;
    logic [PREG_W-1:0] rs2;
    logic              r2;
  } iq_entry_t;

  // Downstream operand-read expects {rs2, rs1, rob}
  function automatic logic [ISSUE_PKT_W-1:0] pack_issue(input iq_entry_t e);
    return {e.rs2, e.rs1, e.rob};
  endfunction

endpackage

// File: rtl/ialu_issue_queue_if.sv
// rtl/ialu_issue_queue_if.sv - dispatch enqueue handshake and issue packet bundle
interface ialu_issue_queue_if;
  import math_pkg::*;

  logic                   enq_valid_i;
  logic                   enq_ready_o;
  logic [ROB_W-1:0]       enq_rob_i;
  logic [PREG_W-1:0]      enq_rs1_i;
  logic                   enq_rs1_rdy_i;
  logic [PREG_W-1:0]      enq_rs2_i;
  logic                   enq_rs2_rdy_i;
  logic [ISSUE_PKT_W-1:0] data_o;
  logic                   valid_o;

  modport master (
    output enq_valid_i, enq_rob_i, enq_rs1_i, enq_rs1_rdy_i, enq_rs2_i, enq_rs2_rdy_i,
    input  enq_ready_o, data_o, valid_o
  );

  modport slave (
    input  enq_valid_i, enq_rob_i, enq_rs1_i, enq_rs1_rdy_i, enq_rs2_i, enq_rs2_rdy_i,
    output enq_ready_o, data_o, valid_o
  );

endinterface

// File: rtl/ialu_issue_queue_select.sv
// rtl/ialu_issue_queue_select.sv - lowest-index (oldest) ready picker
module iq_oldest_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         ready,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_ready
);

  // Scan from the top down so the lowest set bit wins
  always_comb begin
    idx       = '0;
    any_ready = |ready;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) idx = ($clog2(N))'(i);
    end
    grant = any_ready ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/ialu_issue_queue.sv
// rtl/ialu_issue_queue.sv - collapsing age-ordered issue queue for the integer ALU pipe
module ialu_issue_queue
  import math_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WAKE_PORTS = 2
) (
  input  logic                           cpu_clock_i,
  input  logic                           cpu_reset_n_i,
  input  logic                           flush_i,
  input  logic [PREG_W*WAKE_PORTS-1:0]   wake_dest_i,
  input  logic [WAKE_PORTS-1:0]          wake_valid_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  ialu_issue_queue_if.slave              iq
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  iq_entry_t              q     [DEPTH];
  iq_entry_t              q_ext [DEPTH+1];
  iq_entry_t              q_nxt [DEPTH];
  iq_entry_t              new_e;
  logic [DEPTH-1:0]       rdy_mask;
  logic [DEPTH-1:0]       grant;
  logic [IW-1:0]          sel_idx;
  logic                   any_ready;
  logic                   issue_fire;
  logic                   enq_fire;
  logic [CW-1:0]          enq_pos;
  logic [ISSUE_PKT_W-1:0] sel_pkt;

  // Tag 0 is the architectural zero register and never counts as a broadcast
  function automatic logic woken(input logic [PREG_W-1:0]            tag,
                                 input logic [PREG_W*WAKE_PORTS-1:0] dest,
                                 input logic [WAKE_PORTS-1:0]        vld);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (vld[p] && dest[p*PREG_W +: PREG_W] == tag) hit = 1'b1;
    end
    return hit && (tag != '0);
  endfunction

  // Ready mask comes from registered state only, so wakeups take one cycle
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_mask[i] = q[i].valid & q[i].r1 & q[i].r2;
    end
  end

  iq_oldest_select #(.N(DEPTH)) u_select (
    .ready     (rdy_mask),
    .grant     (grant),
    .idx       (sel_idx),
    .any_ready (any_ready)
  );

  assign iq.enq_ready_o = (count_o < CW'(DEPTH));
  assign issue_fire     = any_ready & ~flush_i;
  assign enq_fire       = iq.enq_valid_i & iq.enq_ready_o & ~flush_i;
  assign enq_pos        = count_o - CW'(issue_fire);

  // One-hot mux of the granted entry into the outgoing packet
  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_pkt = sel_pkt | pack_issue(q[i]);
    end
  end

  // Collapse behind the issued slot, apply wakeups, then drop the new op behind the survivors
  always_comb begin
    new_e.valid = 1'b1;
    new_e.rob   = iq.enq_rob_i;
    new_e.rs1   = iq.enq_rs1_i;
    new_e.rs2   = iq.enq_rs2_i;
    new_e.r1    = iq.enq_rs1_rdy_i | (iq.enq_rs1_i == '0) | woken(iq.enq_rs1_i, wake_dest_i, wake_valid_i);
    new_e.r2    = iq.enq_rs2_rdy_i | (iq.enq_rs2_i == '0) | woken(iq.enq_rs2_i, wake_dest_i, wake_valid_i);
    for (int i = 0; i < DEPTH; i++) q_ext[i] = q[i];
    q_ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = (issue_fire && i >= int'(sel_idx)) ? q_ext[i+1] : q_ext[i];
      if (q_nxt[i].valid) begin
        if (woken(q_nxt[i].rs1, wake_dest_i, wake_valid_i)) q_nxt[i].r1 = 1'b1;
        if (woken(q_nxt[i].rs2, wake_dest_i, wake_valid_i)) q_nxt[i].r2 = 1'b1;
      end
      if (enq_fire && CW'(i) == enq_pos) q_nxt[i] = new_e;
    end
  end

  // Queue state, occupancy and the registered issue packet
  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count_o    <= '0;
      iq.valid_o <= 1'b0;
      iq.data_o  <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count_o    <= '0;
      iq.valid_o <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      count_o    <= count_o + CW'(enq_fire) - CW'(issue_fire);
      iq.valid_o <= issue_fire;
      if (issue_fire) iq.data_o <= sel_pkt;
    end
  end

endmodule

// File: tb/tb_ialu_issue_queue.sv
// tb/tb_ialu_issue_queue.sv - directed scoreboard bench for ialu_issue_queue
module tb_ialu_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [11:0] wake_dest = '0;
  logic [1:0]  wake_valid = '0;
  logic [3:0]  count;

  int n_checks = 0;
  int n_pass   = 0;
  int popped   = 0;
  logic [17:0] sb[$];

  ialu_issue_queue_if iq_bus();

  ialu_issue_queue #(.DEPTH(8), .WAKE_PORTS(2)) dut (
    .cpu_clock_i   (clk),
    .cpu_reset_n_i (rst_n),
    .flush_i       (flush),
    .wake_dest_i   (wake_dest),
    .wake_valid_i  (wake_valid),
    .count_o       (count),
    .iq            (iq_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input logic [5:0] rs2, input logic [5:0] rs1, input logic [5:0] rob);
    logic [17:0] v;
    v[17:12] = rs2;
    v[11:6]  = rs1;
    v[5:0]   = rob;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    logic [17:0] e;
    @(posedge clk);
    #1;
    if (iq_bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 32'(iq_bus.valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("issue_pkt", 32'(iq_bus.data_o), 32'(e));
        popped++;
      end
    end
  endtask

  task automatic drive_enq(input logic [5:0] rob, input logic [5:0] rs1, input logic r1,
                           input logic [5:0] rs2, input logic r2);
    iq_bus.enq_valid_i   = 1'b1;
    iq_bus.enq_rob_i     = rob;
    iq_bus.enq_rs1_i     = rs1;
    iq_bus.enq_rs1_rdy_i = r1;
    iq_bus.enq_rs2_i     = rs2;
    iq_bus.enq_rs2_rdy_i = r2;
  endtask

  task automatic idle_enq();
    iq_bus.enq_valid_i = 1'b0;
  endtask

  task automatic wake(input logic [5:0] t0, input logic v0, input logic [5:0] t1, input logic v1);
    wake_dest  = {t1, t0};
    wake_valid = {v1, v0};
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    iq_bus.enq_valid_i   = 1'b0;
    iq_bus.enq_rob_i     = '0;
    iq_bus.enq_rs1_i     = '0;
    iq_bus.enq_rs1_rdy_i = 1'b0;
    iq_bus.enq_rs2_i     = '0;
    iq_bus.enq_rs2_rdy_i = 1'b0;

    #2 rst_n = 1'b0;
    #10;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(iq_bus.valid_o), 32'd0);
    chk("rst_data", 32'(iq_bus.data_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_enq_ready", 32'(iq_bus.enq_ready_o), 32'd1);

    // tag 0 forced ready, two cycles dispatch-to-issue
    sb.push_back(pk(6'd0, 6'd0, 6'd5));
    drive_enq(6'd5, 6'd0, 1'b0, 6'd0, 1'b0);
    step();
    idle_enq();
    chk("t1_no_early_valid", 32'(iq_bus.valid_o), 32'd0);
    chk("t1_count_one", 32'(count), 32'd1);
    step();
    chk("t1_issued", 32'(sb.size()), 32'd0);
    chk("t1_count_zero", 32'(count), 32'd0);

    // younger ready op bypasses an older waiting one
    sb.push_back(pk(6'd4, 6'd3, 6'd2));
    sb.push_back(pk(6'd0, 6'd12, 6'd1));
    drive_enq(6'd1, 6'd12, 1'b0, 6'd0, 1'b0);
    step();
    drive_enq(6'd2, 6'd3, 1'b1, 6'd4, 1'b1);
    step();
    idle_enq();
    wake(6'd12, 1'b1, 6'd0, 1'b0);
    step();
    wake(6'd0, 1'b0, 6'd0, 1'b0);
    chk("t2_b_first", 32'(sb.size()), 32'd1);
    step();
    chk("t2_a_latency", 32'(sb.size()), 32'd0);
    chk("t2_count_zero", 32'(count), 32'd0);

    // wakeup in the enqueue cycle is captured
    sb.push_back(pk(6'd0, 6'd9, 6'd3));
    wake(6'd0, 1'b0, 6'd9, 1'b1);
    drive_enq(6'd3, 6'd9, 1'b0, 6'd0, 1'b0);
    step();
    idle_enq();
    wake(6'd0, 1'b0, 6'd0, 1'b0);
    step();
    chk("t3_bypass", 32'(sb.size()), 32'd0);
    chk("t3_count_zero", 32'(count), 32'd0);

    // fill to full, reject while full, drain oldest-first
    for (int i = 0; i < 8; i++) begin
      drive_enq(6'(i), 6'(10 + i), 1'b0, 6'd0, 1'b0);
      step();
    end
    idle_enq();
    chk("t4_full_not_ready", 32'(iq_bus.enq_ready_o), 32'd0);
    chk("t4_full_count", 32'(count), 32'd8);
    drive_enq(6'h2A, 6'd0, 1'b1, 6'd0, 1'b1);
    step();
    idle_enq();
    chk("t4_full_reject", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) sb.push_back(pk(6'd0, 6'(10 + i), 6'(i)));
    popped = 0;
    for (int k = 0; k < 4; k++) begin
      wake(6'(10 + 2 * k), 1'b1, 6'(11 + 2 * k), 1'b1);
      step();
      chk("t4_count_track", 32'(count), 32'(8 - popped));
    end
    wake(6'd0, 1'b0, 6'd0, 1'b0);
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      step();
      chk("t4_count_track", 32'(count), 32'(8 - popped));
    end
    chk("t4_drained", 32'(sb.size()), 32'd0);
    sb.delete();

    // issue from the middle while enqueuing: collapse and append
    for (int i = 0; i < 5; i++) begin
      drive_enq(6'(20 + i), 6'(30 + i), 1'b0, 6'd0, 1'b0);
      step();
    end
    idle_enq();
    sb.push_back(pk(6'd0, 6'd32, 6'd22));
    sb.push_back(pk(6'd0, 6'd30, 6'd20));
    sb.push_back(pk(6'd0, 6'd31, 6'd21));
    sb.push_back(pk(6'd0, 6'd33, 6'd23));
    sb.push_back(pk(6'd0, 6'd34, 6'd24));
    sb.push_back(pk(6'd0, 6'd40, 6'h3F));
    wake(6'd32, 1'b1, 6'd0, 1'b0);
    step();
    wake(6'd0, 1'b0, 6'd0, 1'b0);
    drive_enq(6'h3F, 6'd40, 1'b0, 6'd0, 1'b0);
    step();
    idle_enq();
    chk("t5_count_same", 32'(count), 32'd5);
    chk("t5_mid_issued", 32'(sb.size()), 32'd5);
    wake(6'd30, 1'b1, 6'd31, 1'b1);
    step();
    wake(6'd33, 1'b1, 6'd34, 1'b1);
    step();
    wake(6'd40, 1'b1, 6'd0, 1'b0);
    step();
    wake(6'd0, 1'b0, 6'd0, 1'b0);
    drain("t5_drain", 20);
    chk("t5_count_zero", 32'(count), 32'd0);

    // flush with a pending select and a coincident enqueue
    for (int i = 0; i < 6; i++) begin
      drive_enq(6'(30 + i), 6'(50 + i), 1'b0, 6'd0, 1'b0);
      step();
    end
    idle_enq();
    chk("t6_count_six", 32'(count), 32'd6);
    wake(6'd50, 1'b1, 6'd0, 1'b0);
    step();
    wake(6'd51, 1'b1, 6'd0, 1'b0);
    flush = 1'b1;
    drive_enq(6'd7, 6'd0, 1'b1, 6'd0, 1'b1);
    step();
    flush = 1'b0;
    idle_enq();
    wake(6'd0, 1'b0, 6'd0, 1'b0);
    chk("t6_flush_valid", 32'(iq_bus.valid_o), 32'd0);
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_ready", 32'(iq_bus.enq_ready_o), 32'd1);
    for (int n = 0; n < 3; n++) step();
    chk("t6_stays_empty", 32'(count), 32'd0);

    // asynchronous reset between clock edges
    sb.push_back(pk(6'd0, 6'd0, 6'd7));
    drive_enq(6'd7, 6'd0, 1'b1, 6'd0, 1'b1);
    step();
    drive_enq(6'd8, 6'd60, 1'b0, 6'd0, 1'b0);
    step();
    idle_enq();
    chk("t7_pre_count", 32'(count), 32'd1);
    chk("t7_pre_valid", 32'(iq_bus.valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", 32'(iq_bus.valid_o), 32'd0);
    chk("t7_async_count", 32'(count), 32'd0);
    chk("t7_async_data", 32'(iq_bus.data_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t7_ready_after", 32'(iq_bus.enq_ready_o), 32'd1);
    chk("t7_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ialu_issue_queue.md
Name: ialu_issue_queue

Overview:
- Collapsing, age-ordered issue queue for the integer ALU/branch pipe; sits directly upstream of the EX00 operand-read stage.
- Accepts renamed micro-ops from dispatch and tracks source readiness via tag wakeups.
- Selects the oldest ready entry each cycle and presents it as an 18-bit packet {rs2[5:0], rs1[5:0], rob[5:0]} with a valid, registered one cycle after select.
- EX00's wakeup_dest/wakeup_valid return on one of the wakeup ports.

Parameters:
- DEPTH, 8, number of queue entries (power of two not required, >=2)
- WAKE_PORTS, 2, number of wakeup tag broadcast ports (port 0 = ALU/EX00, others = load/mul units)

Ports:
- cpu_clock_i  in  1  core clock
- cpu_reset_n_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush; kills all entries and the output packet
- enq_valid_i  in  1  dispatch offers a micro-op
- enq_ready_o  out  1  queue can accept (combinational from occupancy)
- enq_rob_i  in  6  ROB id; bit0 is the fetch-slot bit consumed downstream
- enq_rs1_i  in  6  physical source 1 tag
- enq_rs1_rdy_i  in  1  source 1 already ready at dispatch
- enq_rs2_i  in  6  physical source 2 tag
- enq_rs2_rdy_i  in  1  source 2 already ready at dispatch
- wake_dest_i  in  6*WAKE_PORTS  broadcast destination tags, port p at [6p+5:6p]
- wake_valid_i  in  WAKE_PORTS  per-port wakeup valid
- data_o  out  18  issued packet {rs2, rs1, rob}
- valid_o  out  1  issued packet valid
- count_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async, cpu_reset_n_i low): all entry valids 0, count 0, valid_o 0, data_o 0; enq_ready_o reads 1 once reset releases.
- Entry state: valid, rob[5:0], rs1[5:0], r1, rs2[5:0], r2. Entry 0 is oldest; valid entries are contiguous from 0.
- Tag 0 is architectural zero: a source with tag 0 is forced ready at enqueue regardless of the rdy input.
- Wakeup: for every valid entry, any port p with wake_valid_i[p] and matching wake_dest_i tag sets the matching r bit at the clock edge.
  - The same match applies to the enqueuing micro-op in the same cycle (bypass), so a tag woken in its enqueue cycle is never lost.
  - Tag 0 broadcasts are ignored.
- Select, cycle N: the ready mask is valid & r1 & r2, from registered state only. The lowest-index set bit is chosen.
  - At edge N+1: data_o <= {rs2, rs1, rob} of the chosen entry, valid_o <= 1; the entry is removed.
  - If nothing is ready, valid_o <= 0 and data_o holds its value.
- Wakeup-to-issue latency: a wakeup in cycle N makes the entry selectable in N+1 and valid_o high at N+2.
- Collapse: on removal of index k, entries k+1..count-1 shift to k..count-2. Shifted entries still apply that cycle's wakeups.
- Enqueue: handshake is enq_valid_i & enq_ready_o. The new entry is written at index (count - issued_this_cycle), so it lands behind all survivors.
- enq_ready_o = (count < DEPTH). A full queue does not accept in the same cycle an issue frees a slot; no full-bypass.
- count update: count + enq_fire - issue_fire. count_o is registered.
- Flush: at the edge where flush_i=1, all valids <= 0, count <= 0, valid_o <= 0.
  - A coincident enqueue is dropped; a coincident select is discarded.
  - Wakeups in the flush cycle have no effect.
- No backpressure from downstream: EX00 always accepts, and valid_o is a single-cycle pulse per issued op.
- Same-cycle enqueue of an entry with both sources ready: not selectable until the following cycle; minimum dispatch-to-valid_o is 2 cycles.
- Multiple ports matching the same tag in one cycle: harmless OR.

Decomposition:
- Shared package math_pkg holds:
  - PREG_W=6, ROB_W=6
  - typedef iq_entry_t {valid, rob, rs1, r1, rs2, r2}
  - ISSUE_PKT_W=18 and a pack function for {rs2, rs1, rob}
- One sub-module is natural: iq_oldest_select. It takes a DEPTH-bit ready mask and returns a one-hot grant, a binary index and any_ready, and is reusable by the memory queue.
- Wakeup CAM and collapse logic stay in the top module.

Test Plan:
- Reset then enqueue rob=5, rs1=0, rs2=0, rdy=0/0 -> tag-0 forced ready; valid_o=1 with data_o={6'd0, 6'd0, 6'd5} two cycles after the enqueue fire; count_o returns to 0.
- Enqueue A(rob=1, rs1=12 not ready), then B(rob=2, ready); wake tag 12 on port 0 in the cycle after A's enqueue -> issue order is B, then A; A's valid_o is two cycles after the wakeup.
- Enqueue with rs1=9 not ready while wake_dest port1=9 is valid in the same cycle -> bypass captured; entry issues without a further wakeup.
- Fill 8 entries, none ready -> enq_ready_o=0 and count_o=8. Wake all tags -> entries issue oldest-first, rob 0..7 one per cycle, and the queue stays contiguous (check after each removal).
- Issue index 2 of 5 while enqueuing rob=0x3F in the same cycle -> new entry lands at index 4, count_o unchanged at 5, no entry lost or duplicated.
- Flush with 6 entries, a pending valid_o and a simultaneous enqueue -> next cycle valid_o=0, count_o=0, enq_ready_o=1. Assert cpu_reset_n_i low mid-stream -> outputs clear immediately, without waiting for a clock edge.
